// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x oversampling UART receiver with a first-word-fall-through
// RX FIFO read through a valid/ready handshake.
// Build option: define UART_RX_MAJORITY_EN to decide each bit (start check
// included) by 2-of-3 majority of the samples at os_cnt 7/8/9. Without it,
// the single sample at os_cnt 8 is used. Frame timing is the same either way.
module uart_rx_core #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          app_clk,
  input  logic          reset_n,
  input  logic          cfg_rx_en,
  input  logic [11:0]   cfg_baud,
  input  logic [1:0]    cfg_data_bits,
  input  logic          cfg_stop_2,
  input  logic          cfg_parity_en,
  input  logic          cfg_even_par,
  input  logic          rxd,
  output logic [7:0]    rx_data,
  output logic          rx_perr,
  output logic          rx_ferr,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [FW-1:0] rx_fifo_cnt,
  output logic          rx_overrun,
  input  logic          err_clr,
  output logic          rx_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BREAK
  } state_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_word_t;

  logic rxd_m, rxd_s, rxd_d;
  logic [11:0] baud_cnt;
  logic tick;
  state_t state_q;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_q;
  logic perr_q, ferr_q, stop0_q;
  logic s8_q;
  logic bit_v, mid_pt, last_bit, ferr_fin, all0_fin, brk_fin;
  logic push_q;
  rx_word_t push_word;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign tick = cfg_rx_en && (baud_cnt == 12'd0);

  // Oversample tick divider; held in reload while the receiver is off
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= 12'd0;
    end else if (!cfg_rx_en || tick) begin
      baud_cnt <= cfg_baud;
    end else begin
      baud_cnt <= baud_cnt - 12'd1;
    end
  end

  // Mid-bit sample capture; the bit decision is taken at os_cnt 9
`ifdef UART_RX_MAJORITY_EN
  logic s7_q;
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (tick) begin
      if (os_cnt == 4'd7) s7_q <= rxd_s;
      if (os_cnt == 4'd8) s8_q <= rxd_s;
    end
  end
  assign bit_v = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);
`else
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      s8_q <= 1'b1;
    end else if (tick && (os_cnt == 4'd8)) begin
      s8_q <= rxd_s;
    end
  end
  assign bit_v = s8_q;
`endif

  assign mid_pt   = tick && (os_cnt == 4'd9);
  assign last_bit = (bit_idx == (3'(cfg_data_bits) + 3'd4));
  assign ferr_fin = ((state_q == ST_STOP2) ? ferr_q : 1'b0) | ~bit_v;
  assign all0_fin = ((state_q == ST_STOP2) ? stop0_q : 1'b1) & ~bit_v;
  assign brk_fin  = all0_fin && (shift_q == 8'd0);

  // Frame FSM: start validation, data shift, parity/stop checks, push request
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      os_cnt    <= 4'd0;
      bit_idx   <= 3'd0;
      shift_q   <= 8'd0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      stop0_q   <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= 1'b0;
      if (!cfg_rx_en) begin
        state_q <= ST_IDLE;
        os_cnt  <= 4'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rxd_d && !rxd_s) begin
              state_q <= ST_START;
              os_cnt  <= 4'd0;
            end
          end
          ST_BREAK: begin
            if (rxd_s) state_q <= ST_IDLE;
          end
          default: begin
            if (tick) os_cnt <= os_cnt + 4'd1;
            if (mid_pt) begin
              case (state_q)
                ST_START: begin
                  if (bit_v) begin
                    state_q <= ST_IDLE;
                  end else begin
                    state_q <= ST_DATA;
                    bit_idx <= 3'd0;
                    shift_q <= 8'd0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                  end
                end
                ST_DATA: begin
                  shift_q[bit_idx] <= bit_v;
                  bit_idx          <= bit_idx + 3'd1;
                  if (last_bit) state_q <= cfg_parity_en ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: begin
                  perr_q  <= (^shift_q) ^ bit_v ^ ~cfg_even_par;
                  state_q <= ST_STOP1;
                end
                ST_STOP1, ST_STOP2: begin
                  ferr_q  <= ferr_fin;
                  stop0_q <= all0_fin;
                  if ((state_q == ST_STOP1) && cfg_stop_2) begin
                    state_q <= ST_STOP2;
                  end else begin
                    push_q    <= 1'b1;
                    push_word <= '{ferr: ferr_fin, perr: perr_q, data: shift_q};
                    state_q   <= brk_fin ? ST_BREAK : ST_IDLE;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign rx_busy = (state_q != ST_IDLE);

  rx_word_t mem [FIFO_DEPTH];
  rx_word_t last_q, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, pop, wr_en;

  assign full  = (rx_fifo_cnt == FW'(FIFO_DEPTH));
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push_q && (!full || pop);

  // RX FIFO storage, pointers, occupancy and sticky overrun
  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      last_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_fifo_cnt <= '0;
      rx_overrun  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      rx_fifo_cnt <= rx_fifo_cnt + FW'(wr_en) - FW'(pop);
      if (push_q && full && !pop) begin
        rx_overrun <= 1'b1;
      end else if (err_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_valid = (rx_fifo_cnt != FW'(0));
  assign head     = rx_valid ? mem[rd_ptr] : last_q;
  assign rx_data  = head.data;
  assign rx_perr  = head.perr;
  assign rx_ferr  = head.ferr;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a serial agent drives rxd while a queue
// model of expected characters is checked against the FIFO head every cycle.
module tb_uart_rx_core;

  logic        app_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_rx_en = 1'b1;
  logic [11:0] cfg_baud = 12'd0;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic        cfg_stop_2 = 1'b0;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_even_par = 1'b1;
  logic        rxd = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid;
  logic        rx_ready = 1'b1;
  logic [2:0]  rx_fifo_cnt;
  logic        rx_overrun;
  logic        err_clr = 1'b0;
  logic        rx_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_q [$];
  logic [9:0] nxt;

  uart_rx_core #(.FIFO_DEPTH(4), .FW(3)) dut (
    .app_clk(app_clk), .reset_n(reset_n), .cfg_rx_en(cfg_rx_en),
    .cfg_baud(cfg_baud), .cfg_data_bits(cfg_data_bits), .cfg_stop_2(cfg_stop_2),
    .cfg_parity_en(cfg_parity_en), .cfg_even_par(cfg_even_par), .rxd(rxd),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_fifo_cnt(rx_fifo_cnt), .rx_overrun(rx_overrun),
    .err_clr(err_clr), .rx_busy(rx_busy)
  );

  always #5 app_clk = ~app_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge app_clk);
    #1;
  endtask

  // Expected character: receiver sees masked data; parity error when the
  // agent's parity sense differs from the configured one; ferr on bad stop.
  task automatic push_exp(input logic [9:0] w);
    if (!rx_ready && exp_q.size() >= 4) begin
      // FIFO full with nobody reading: character is lost
    end else begin
      exp_q.push_back(w);
    end
  endtask

  task automatic send_char(input logic [7:0] d, input bit a_even, input bit stop_err,
                           input bit expect_it);
    int nb, bc;
    logic [7:0] dm;
    logic pbit;
    nb = 5 + int'(cfg_data_bits);
    bc = 16 * (int'(cfg_baud) + 1);
    dm = d & 8'((1 << nb) - 1);
    pbit = a_even ? (^dm) : ~(^dm);
    if (expect_it)
      push_exp({stop_err, cfg_parity_en && (a_even != cfg_even_par), dm});
    rxd = 1'b0;
    repeat (bc) step();
    for (int i = 0; i < nb; i++) begin
      rxd = dm[i];
      repeat (bc) step();
    end
    if (cfg_parity_en) begin
      rxd = pbit;
      repeat (bc) step();
    end
    for (int s = 0; s < (cfg_stop_2 ? 2 : 1); s++) begin
      rxd = ~stop_err;
      repeat (bc) step();
    end
    rxd = 1'b1;
  endtask

  task automatic wait_cnt(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (int'(rx_fifo_cnt) == n) break;
      step();
    end
    check("fifo_cnt", 32'(rx_fifo_cnt), 32'(n));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0 && !rx_valid) break;
      step();
    end
    check("drain_model_q", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(rx_valid), 32'd0);
  endtask

  // Head of the FIFO must match the model's oldest outstanding character
  always @(negedge app_clk) begin
    if (reset_n) begin
      check("cnt_vs_valid", 32'(rx_valid), 32'(rx_fifo_cnt != 3'd0));
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", {22'd0, rx_ferr, rx_perr, rx_data}, 32'h3ff);
        end else begin
          nxt = exp_q[0];
          check("head", {22'd0, rx_ferr, rx_perr, rx_data}, {22'd0, nxt});
          if (rx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset values
    #2;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_flags", {30'd0, rx_perr, rx_ferr}, 0);
    check("rst_cnt", 32'(rx_fifo_cnt), 0);
    check("rst_ovr", 32'(rx_overrun), 0);
    check("rst_busy", 32'(rx_busy), 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (4) step();

    // 8N1, 16 clocks per bit
    rx_ready = 1'b0;
    send_char(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_cnt(1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_flags", {30'd0, rx_perr, rx_ferr}, 0);
    rx_ready = 1'b1;
    wait_drain();

    // 7E2 back-to-back, then odd-parity agent
    cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_even_par = 1'b1; cfg_stop_2 = 1'b1;
    step();
    send_char(8'h55, 1'b1, 1'b0, 1'b1);
    send_char(8'h2A, 1'b1, 1'b0, 1'b1);
    wait_drain();
    rx_ready = 1'b0;
    send_char(8'h55, 1'b0, 1'b0, 1'b1);
    send_char(8'h2A, 1'b0, 1'b0, 1'b1);
    wait_cnt(2);
    check("odd_perr", 32'(rx_perr), 1);
    check("odd_data", 32'(rx_data), 32'h55);
    rx_ready = 1'b1;
    wait_drain();

    // Framing error, then a short glitch that must not produce a character
    cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop_2 = 1'b0;
    step();
    rx_ready = 1'b0;
    send_char(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_cnt(1);
    check("ferr_flag", 32'(rx_ferr), 1);
    check("ferr_data", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    wait_drain();
    cfg_baud = 12'd3;
    repeat (70) step();
    rxd = 1'b0;
    repeat (20) step();
    rxd = 1'b1;
    repeat (64 * 12) step();
    check("glitch_valid", 32'(rx_valid), 0);
    check("glitch_busy", 32'(rx_busy), 0);
    cfg_baud = 12'd0;
    repeat (4) step();

    // Overrun with FIFO full
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_char(8'(i), 1'b1, 1'b0, 1'b1);
    repeat (8) step();
    check("ovr_cnt", 32'(rx_fifo_cnt), 4);
    check("ovr_flag", 32'(rx_overrun), 1);
    check("ovr_head", 32'(rx_data), 32'h01);
    rx_ready = 1'b1;
    wait_drain();
    check("ovr_sticky", 32'(rx_overrun), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_clr", 32'(rx_overrun), 0);

    // Break: line low for 30 bit times
    push_exp({1'b1, 1'b0, 8'h00});
    rxd = 1'b0;
    repeat (30 * 16) step();
    check("break_busy", 32'(rx_busy), 1);
    rxd = 1'b1;
    repeat (32) step();
    check("break_exit", 32'(rx_busy), 0);
    wait_drain();
    send_char(8'h81, 1'b1, 1'b0, 1'b1);
    wait_drain();
    check("hold_last", 32'(rx_data), 32'h81);

    // Receiver disabled mid-frame discards the partial character
    fork
      send_char(8'h11, 1'b1, 1'b0, 1'b0);
      begin
        repeat (4 * 16) step();
        cfg_rx_en = 1'b0;
        step();
        check("dis_busy", 32'(rx_busy), 0);
      end
    join
    repeat (8) step();
    cfg_rx_en = 1'b1;
    repeat (4) step();
    send_char(8'h7E, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Async reset mid-frame with a held entry
    rx_ready = 1'b0;
    send_char(8'h5A, 1'b1, 1'b0, 1'b1);
    wait_cnt(1);
    fork
      send_char(8'h33, 1'b1, 1'b0, 1'b0);
      begin
        repeat (3 * 16) step();
        check("pre_rst_busy", 32'(rx_busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rx_valid), 0);
        check("mid_rst_cnt", 32'(rx_fifo_cnt), 0);
        check("mid_rst_data", 32'(rx_data), 0);
        check("mid_rst_busy", 32'(rx_busy), 0);
      end
    join
    exp_q.delete();
    step();
    reset_n = 1'b1;
    rx_ready = 1'b1;
    repeat (40) step();
    check("post_rst_valid", 32'(rx_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
